pipe_sched: RTL
===============

// Module: pipe_sched
// PURPOSE
//  Pipeline stall/flush scheduler for the 5-stage CPU; sits beside the forwarding unit.
//  - Detects load-use hazards that forwarding cannot cover.
//  - Kills the wrong-path fetch on a taken branch resolved in ID.
//  - Sequences the multi-cycle mult/div unit: start pulse, hold pipeline, HI/LO write strobe.
// PARAMETERS
//  MUL_CYCLES  4   mult latency in cycles, request to result; must be >= 2
//  DIV_CYCLES  32  div latency in cycles, request to result; must be >= 2
//  CNT_W       6   countdown width; must hold max(MUL_CYCLES,DIV_CYCLES)-1
// PORTS
//  clk             in   1  system clock, rising edge
//  rst_n           in   1  asynchronous active-low reset
//  rs_id           in   5  rs of instruction in ID
//  rt_id           in   5  rt of instruction in ID
//  write_reg_ex    in   5  destination register of instruction in EX
//  cu_mem_to_reg_ex in  1  EX instruction is a load
//  branch_taken_id in   1  branch in ID resolved taken
//  md_req_ex       in   1  EX instruction is mult/div
//  md_div_ex       in   1  1=div, 0=mult (valid with md_req_ex)
//  stall_if        out  1  hold PC
//  stall_id        out  1  hold IF/ID register
//  stall_ex        out  1  hold ID/EX register
//  flush_id        out  1  clear IF/ID register (bubble into ID)
//  flush_ex        out  1  clear ID/EX register (bubble into EX)
//  flush_mem       out  1  clear EX/MEM register (bubble into MEM)
//  md_start        out  1  one-cycle start pulse to mult/div unit
//  md_is_div       out  1  registered op type of the running operation
//  md_busy         out  1  mult/div sequence in progress
//  hilo_we         out  1  one-cycle HI/LO write strobe
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=IDLE, cnt=0, md_is_div=0.
//   - All outputs forced 0 while rst_n=0, including combinational ones.
//   - Reset mid-sequence abandons the operation; no hilo_we is issued.
//  Load-use, combinational: lu = cu_mem_to_reg_ex & write_reg_ex!=0
//   & (write_reg_ex==rs_id | write_reg_ex==rt_id).
//  Mult/div FSM (states IDLE, BUSY, DONE), N = md_is_div ? DIV_CYCLES : MUL_CYCLES
//   - IDLE & md_req_ex:
//     - md_start=1 and md stall asserted in the same cycle.
//     - At the edge: BUSY, cnt=N-1, md_is_div<=md_div_ex.
//   - BUSY: md stall asserted, cnt decrements each cycle; cnt==1 -> DONE.
//   - DONE: hilo_we=1, no md stall, EX instruction advances. Unconditional -> IDLE.
//     md_req_ex is ignored in DONE, so the same instruction never restarts.
//   - Timing: stall cycles = N exactly (request cycle + N-1 BUSY cycles);
//     hilo_we occurs N cycles after the request cycle.
//   - md_busy = (state==BUSY) | (state==IDLE & md_req_ex).
//  Outputs, by priority
//   1. md stall (md_busy):
//      - stall_if=stall_id=stall_ex=1, flush_mem=1.
//      - flush_id=flush_ex=0; lu and branch are ignored this cycle and re-evaluated on release.
//   2. lu:
//      - stall_if=stall_id=1, flush_ex=1.
//      - flush_id=0, so a branch waiting on the load holds.
//   3. branch_taken_id: flush_id=1 only.
//   4. Otherwise all outputs 0 (except hilo_we in DONE).
//  Other rules
//   - md_start never coincides with hilo_we.
//   - Back-to-back mult/div: the second request is seen in IDLE the cycle after DONE.
// TESTING
//  1. lw r2 in EX, ID reads rs=2:
//     -> stall_if=stall_id=flush_ex=1 for one cycle; r0 dest -> no stall.
//  2. Taken branch in ID, no hazard -> flush_id=1 one cycle, no stalls.
//     Branch plus lu -> flush_id=0, stall only.
//  3. mult request (MUL_CYCLES=4) at cycle t:
//     -> md_start@t; stall_ex=flush_mem=1 for t..t+3; hilo_we@t+4 only.
//  4. div request -> 32 stall cycles, md_is_div=1, hilo_we@t+32.
//     Mult immediately after -> new md_start@t+33.
//  5. Assert rst_n=0 during BUSY (cnt=10):
//     -> all outputs 0 immediately; after release state IDLE, no hilo_we.
//  6. md request with lu and branch_taken_id in the same cycle:
//     -> only md stall pattern asserted; flush_id=flush_ex=0.

Source files
------------

// File: rtl/pipe_sched.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Covers load-use hazards, taken-branch kills and mult/div sequencing.
`timescale 1ns/1ps
module pipe_sched #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [4:0] write_reg_ex,
  input  logic       cu_mem_to_reg_ex,
  input  logic       branch_taken_id,
  input  logic       md_req_ex,
  input  logic       md_div_ex,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic       md_start,
  output logic       md_is_div,
  output logic       md_busy,
  output logic       hilo_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [CNT_W-1:0] MUL_N1 = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_N1 = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             div_nx;
  logic             start_c, busy_c, hilo_c;
  logic             lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      md_is_div <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      md_is_div <= div_nx;
    end
  end

  // DONE ignores md_req_ex so the finishing op cannot restart itself
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = md_is_div;
    start_c  = 1'b0;
    busy_c   = 1'b0;
    hilo_c   = 1'b0;
    case (state)
      IDLE: begin
        if (md_req_ex) begin
          start_c  = 1'b1;
          busy_c   = 1'b1;
          state_nx = BUSY;
          div_nx   = md_div_ex;
          cnt_nx   = md_div_ex ? DIV_N1 : MUL_N1;
        end
      end
      BUSY: begin
        busy_c = 1'b1;
        cnt_nx = cnt - ONE;
        if (cnt == ONE) state_nx = DONE;
      end
      DONE: begin
        hilo_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign lu = cu_mem_to_reg_ex
            & (write_reg_ex != 5'd0)
            & ((write_reg_ex == rs_id)
             | (write_reg_ex == rt_id));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    hilo_we   = 1'b0;
    // gate on rst_n so combinational paths are quiet during reset
    if (rst_n) begin
      md_start = start_c;
      md_busy  = busy_c;
      hilo_we  = hilo_c;
      if (busy_c) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
      end else if (lu) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (branch_taken_id) begin
        flush_id = 1'b1;
      end
    end
  end

endmodule
